// File: rtl/ab_stim_gen.sv
// Stimulus generator for the "a |=> b" handshake: issues request/response pairs
// with fixed or LFSR-driven idle gaps and deliberately omits every Kth response.
module ab_stim_gen #(
  parameter int          CNT_W     = 8,
  parameter int          GAP_W     = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_txn,
  input  logic [CNT_W-1:0] err_every,
  input  logic             gap_mode,
  input  logic [GAP_W-1:0] gap_len,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] txn_cnt,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic [2:0] {IDLE, GAP, REQ, RSP, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t           state, nxt;
  logic [CNT_W-1:0] num_q, err_q, err_ctr;
  logic             mode_q;
  logic [GAP_W-1:0] glen_q, gap_ctr;
  logic             inject;
  logic [15:0]      lfsr;

  // In IDLE the live inputs stand in for the config registers, so the start
  // cycle sees the configuration it is about to latch.
  logic             cfg_mode;
  logic [GAP_W-1:0] cfg_len, gap_val;
  logic [CNT_W-1:0] err_k, ctr_cur, txn_base;

  always_comb begin
    cfg_mode = (state == IDLE) ? gap_mode  : mode_q;
    cfg_len  = (state == IDLE) ? gap_len   : glen_q;
    err_k    = (state == IDLE) ? err_every : err_q;
    ctr_cur  = (state == IDLE) ? err_every : err_ctr;
    txn_base = (state == IDLE) ? '0        : txn_cnt;
    gap_val  = cfg_mode ? (lfsr[GAP_W-1:0] & cfg_len) : cfg_len;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) begin
        if (num_txn == '0)       nxt = DONE;
        else if (gap_val != '0)  nxt = GAP;
        else                     nxt = REQ;
      end
      GAP:  if (gap_ctr == GAP_ONE) nxt = REQ;
      REQ:  nxt = RSP;
      RSP: begin
        if (txn_cnt == num_q)    nxt = DONE;
        else if (gap_val != '0)  nxt = GAP;
        else                     nxt = REQ;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign a    = (state == REQ);
  assign b    = (state == RSP) && !inject;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Counters update on entry to REQ/RSP so pass+fail==txn everywhere but REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lfsr     <= LFSR_SEED;
      num_q    <= '0;
      err_q    <= '0;
      mode_q   <= 1'b0;
      glen_q   <= '0;
      err_ctr  <= '0;
      gap_ctr  <= '0;
      inject   <= 1'b0;
      txn_cnt  <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      state <= nxt;
      lfsr  <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      if (state == IDLE && start) begin
        num_q    <= num_txn;
        err_q    <= err_every;
        mode_q   <= gap_mode;
        glen_q   <= gap_len;
        err_ctr  <= err_every;
        txn_cnt  <= '0;
        pass_cnt <= '0;
        fail_cnt <= '0;
      end
      if (nxt == GAP)
        gap_ctr <= (state == GAP) ? gap_ctr - GAP_ONE : gap_val;
      if (nxt == REQ) begin
        txn_cnt <= txn_base + CNT_ONE;
        inject  <= (err_k != '0) && (ctr_cur == CNT_ONE);
        err_ctr <= (ctr_cur <= CNT_ONE) ? err_k : ctr_cur - CNT_ONE;
      end
      if (state == REQ) begin
        if (inject) fail_cnt <= fail_cnt + CNT_ONE;
        else        pass_cnt <= pass_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/ab_stim_gen.md
# ab_stim_gen

Stimulus generator for the single-cycle request/response handshake "a |=> b": it drives `a` and `b` to exercise that property's pass, fail and vacuous cases. It sits in the testbench/DUT harness directly upstream of the checker and gives the checker a known mix of transactions. It also counts how many responses it produced correctly and how many it deliberately omitted, so checker results can be reconciled cycle-exactly.

## Interface
- `CNT_W`, 8, width of transaction count, error-interval and result counters
- `GAP_W`, 4, width of idle-gap length
- `LFSR_SEED`, 16'hACE1, non-zero reset value of the 16-bit gap LFSR
- `clk`  in  1  clock; all logic on posedge
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  launch a run; sampled only in IDLE
- `num_txn`  in  CNT_W  transactions per run; latched on start
- `err_every`  in  CNT_W  omit `b` on every Kth transaction; 0 = never; latched on start
- `gap_mode`  in  1  0 = fixed gap, 1 = LFSR gap; latched on start
- `gap_len`  in  GAP_W  fixed gap length, or AND-mask on LFSR gap; latched on start
- `a`  out  1  request (registered)
- `b`  out  1  response (registered)
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle end-of-run pulse
- `txn_cnt`  out  CNT_W  transactions issued this run
- `pass_cnt`  out  CNT_W  transactions answered with `b`
- `fail_cnt`  out  CNT_W  transactions with `b` omitted

## Operation
- FSM states: IDLE, GAP, REQ, RSP, DONE. Outputs decode from the registered state; `a` = (state==REQ), `b` = (state==RSP && !inject).
- IDLE: `start`=1 latches configuration and clears all counters. Next state is DONE if `num_txn`==0, GAP if gap>0, else REQ. Reload the error down-counter with `err_every`.
- gap = `gap_len` when `gap_mode`=0; `lfsr[GAP_W-1:0] & gap_len` when `gap_mode`=1. It is computed each time GAP is entered.
- GAP: lasts exactly gap cycles with `a`=`b`=0, then goes to REQ.
- REQ: one cycle. `txn_cnt`++. inject = (err_every!=0 && err_ctr==1). The down-counter decrements, reloading to `err_every` at 1.
- RSP: one cycle. `pass_cnt`++ if !inject, else `fail_cnt`++. Next state is DONE if `txn_cnt`==`num_txn`, else GAP (gap>0) or REQ (gap==0).
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in GAP, REQ, RSP and DONE.
- Invariant: `pass_cnt`+`fail_cnt`==`txn_cnt` in every cycle outside REQ.
- Counters hold their final values in IDLE until the next `start`. No overflow is possible because `txn_cnt` ≤ `num_txn` ≤ 2^CNT_W−1.
- `start` during `busy` is ignored. Configuration inputs are ignored except on an accepted start.
- LFSR: Galois, taps x^16+x^14+x^13+x^11+1. It advances every cycle when not in reset.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, all counters 0, FSM=IDLE, LFSR=`LFSR_SEED`.
- Reset asserted mid-run has the same effect at the next edge: the run is abandoned and no `done` is issued.
- Start accepted at edge T: the FSM is in REQ/GAP/DONE during cycle T+1.
- With gap 0, `a` is high in cycle T+1 and `b` in T+2.
- Period per transaction is 2+gap cycles.
- `a` and `b` are never high in the same cycle.
- `b`, when driven, is exactly one cycle after `a`.
- `done` follows the last RSP by one cycle. `busy` drops the cycle after `done`.
- A new `start` is accepted in the first IDLE cycle after `done`.

## Test plan
- `num_txn`=3, `err_every`=0, `gap_mode`=0, `gap_len`=0, start at T:
  - `a` high at T+1, T+3, T+5; `b` high at T+2, T+4, T+6
  - `done` at T+7; `busy` low at T+8
  - counters 3/3/0
- `num_txn`=4, `err_every`=2, `gap_len`=2 fixed:
  - `a` at T+3, T+7, T+11, T+15
  - `b` present after txns 1 and 3, absent after 2 and 4
  - `pass_cnt`=2, `fail_cnt`=2, `done` at T+17
- `num_txn`=0: `done` at T+1, `a`/`b` never high, counters 0. Also `err_every`=1, `num_txn`=5: `b` never high, `fail_cnt`=5.
- `gap_mode`=1:
  - `gap_len`=0 is identical to the first scenario.
  - `gap_len`=4'hF, `num_txn`=50: every gap is in 0..15 and matches a reference LFSR model.
  - Invariant holds throughout; `txn_cnt`=50.
- `start` pulsed during REQ/GAP is ignored and the run is unchanged.
- `reset` asserted in RSP of txn 2: next cycle `a`=`b`=`busy`=0, counters 0, no `done`. A fresh start then runs normally.
